knn_topk_sort_ctrl: RTL



---
 rtl/knn_topk_sort_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/knn_topk_sort_ctrl.sv
// knn_topk_sort_ctrl
// Keeps a running list of the 16 smallest distances for one KNN query by
// passing each accepted candidate, together with the current best list,
// through a shared external 17-input ascending sorter. The largest of the
// 17 sorted values is dropped. Unused list slots hold all-ones; res_count
// says how many slots are real.
module knn_topk_sort_ctrl #(
    parameter int W        = 32,
    parameter int SORT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cand_valid,
    output logic              cand_ready,
    input  logic [W-1:0]      cand_data,
    input  logic              cand_last,
    output logic [17*W-1:0]   srt_din,
    input  logic [17*W-1:0]   srt_dout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [16*W-1:0]   res_data,
    output logic [4:0]        res_count,
    output logic              busy
);

    localparam int NBEST = 16;
    localparam int CNT_W = $clog2(SORT_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        SORT,
        RESULT
    } state_t;

    state_t                 state_q, state_d;
    logic [NBEST*W-1:0]     best_q, best_d;
    logic [W-1:0]           cand_q, cand_d;
    logic                   last_q, last_d;
    logic [4:0]             count_q, count_d;
    logic [CNT_W-1:0]       wait_q, wait_d;
    logic                   cand_ready_q, cand_ready_d;
    logic                   res_valid_q, res_valid_d;
    logic                   busy_q, busy_d;

    // Slot 16 of the sorter output is the largest of 17 and is discarded.
    logic                   unused_slot16;
    assign unused_slot16 = ^srt_dout[NBEST*W +: W];

    // Entry count grows by one per sorted candidate and saturates at 16.
    function automatic logic [4:0] sat_inc(input logic [4:0] c);
        return (c >= 5'd16) ? 5'd16 : c + 5'd1;
    endfunction

    // Next-state and datapath-update logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        best_d  = best_q;
        cand_d  = cand_q;
        last_d  = last_q;
        count_d = count_q;
        wait_d  = wait_q;

        if (abort) begin
            state_d = IDLE;
            wait_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        best_d  = '1;
                        count_d = 5'd0;
                        state_d = ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (cand_valid && cand_ready_q) begin
                        cand_d  = cand_data;
                        last_d  = cand_last;
                        wait_d  = CNT_W'(SORT_LAT);
                        state_d = SORT;
                    end
                end
                SORT: begin
                    wait_d = wait_q - CNT_W'(1);
                    if (wait_q == CNT_W'(1)) begin
                        best_d  = srt_dout[NBEST*W-1:0];
                        count_d = sat_inc(count_q);
                        state_d = last_q ? RESULT : ACCEPT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Handshake/status outputs are registered, decoded from the next state.
        cand_ready_d = (state_d == ACCEPT);
        res_valid_d  = (state_d == RESULT);
        busy_d       = (state_d != IDLE);
    end

    // State, list registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            best_q       <= '1;
            cand_q       <= '1;
            last_q       <= 1'b0;
            count_q      <= 5'd0;
            wait_q       <= '0;
            cand_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            best_q       <= best_d;
            cand_q       <= cand_d;
            last_q       <= last_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
            cand_ready_q <= cand_ready_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Sorter input comes from registers only, so it is stable throughout SORT.
    assign srt_din    = {cand_q, best_q};
    assign cand_ready = cand_ready_q;
    assign res_valid  = res_valid_q;
    assign res_data   = best_q;
    assign res_count  = count_q;
    assign busy       = busy_q;

endmodule
